// File: rtl/fpdivide.sv
`default_nettype none
// ============================================================================
// Module   : fpdivide
// Brief    : Sequential signed fixed-point divider (restoring, 1 bit/clock)
//            with saturation, overflow/underflow and divide-by-zero flags.
// Revision : 1.0
// ============================================================================
module fpdivide #(
    parameter int int1     = 6,
    parameter int frac1    = 8,
    parameter int int2     = 5,
    parameter int frac2    = 7,
    parameter int out_int  = 6,
    parameter int out_frac = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [int1+frac1-1:0]         a,
    input  logic [int2+frac2-1:0]         b,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          div_zero,
    output logic [out_int+out_frac-1:0]   quotient
);

    localparam int AW = int1 + frac1;
    localparam int BW = int2 + frac2;
    localparam int OW = out_int + out_frac;
    localparam int SH = out_frac + frac2 - frac1;
    localparam int NW = AW + SH;
    localparam int CW = $clog2(NW);
    localparam int EW = NW + OW + 1;

    localparam logic [CW-1:0] c_last    = CW'(NW - 1);
    localparam logic [OW-1:0] c_max     = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] c_min     = {1'b1, {(OW-1){1'b0}}};
    localparam logic [EW-1:0] c_pos_lim = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic [EW-1:0] c_neg_lim = c_pos_lim + EW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_sign;
    logic            r_asgn;
    logic            r_bz;
    logic [BW-1:0]   r_bmag;
    logic [NW-1:0]   r_num;
    logic [BW-1:0]   r_rem;
    logic [NW-1:0]   r_qmag;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic            r_ov;
    logic            r_un;
    logic            r_dz;
    logic [OW-1:0]   r_quot;

    logic [AW-1:0]   w_a_mag;
    logic [BW-1:0]   w_b_mag;
    logic [BW:0]     w_trial;
    logic            w_ge;
    logic [BW:0]     w_diff;
    logic [EW-1:0]   w_mag_ext;
    logic [OW-1:0]   w_q_res;
    logic            w_ov;
    logic            w_un;

    assign w_a_mag = a[AW-1] ? (~a + AW'(1)) : a;
    assign w_b_mag = b[BW-1] ? (~b + BW'(1)) : b;

    // Partial remainder stays below |b|, so one extra bit covers the shifted trial value.
    assign w_trial = {r_rem, r_num[NW-1]};
    assign w_ge    = (w_trial >= {1'b0, r_bmag});
    assign w_diff  = w_ge ? (w_trial - {1'b0, r_bmag}) : w_trial;

    assign w_mag_ext = {{(EW-NW){1'b0}}, r_qmag};

    always_comb begin
        w_q_res = w_mag_ext[OW-1:0];
        w_ov    = 1'b0;
        w_un    = 1'b0;
        if (r_bz) begin
            if (r_asgn) begin
                w_q_res = c_min;
                w_un    = 1'b1;
            end else begin
                w_q_res = c_max;
                w_ov    = 1'b1;
            end
        end else if (!r_sign && (w_mag_ext > c_pos_lim)) begin
            w_q_res = c_max;
            w_ov    = 1'b1;
        end else if (r_sign && (w_mag_ext > c_neg_lim)) begin
            w_q_res = c_min;
            w_un    = 1'b1;
        end else if (r_sign) begin
            w_q_res = ~w_mag_ext[OW-1:0] + OW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == c_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign <= 1'b0;
            r_asgn <= 1'b0;
            r_bz   <= 1'b0;
            r_bmag <= '0;
            r_num  <= '0;
            r_rem  <= '0;
            r_qmag <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_ov   <= 1'b0;
            r_un   <= 1'b0;
            r_dz   <= 1'b0;
            r_quot <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= a[AW-1] ^ b[BW-1];
                        r_asgn <= a[AW-1];
                        r_bz   <= (b == '0);
                        r_bmag <= w_b_mag;
                        r_num  <= NW'(w_a_mag) << SH;
                        r_rem  <= '0;
                        r_qmag <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_diff[BW-1:0];
                    r_num  <= {r_num[NW-2:0], 1'b0};
                    r_qmag <= {r_qmag[NW-2:0], w_ge};
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_quot <= w_q_res;
                    r_ov   <= w_ov;
                    r_un   <= w_un;
                    r_dz   <= r_bz;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign overflow  = r_ov;
    assign underflow = r_un;
    assign div_zero  = r_dz;
    assign quotient  = r_quot;

endmodule
`default_nettype wire

// File: tb/tb_fpdivide.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpdivide
// Brief    : Table-driven, scoreboard-checked bench for fpdivide.
// Revision : 1.0
// ============================================================================
module tb_fpdivide;

    localparam int AW = 14;
    localparam int BW = 12;
    localparam int OW = 15;
    localparam int NW = 22;
    localparam int NV = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          underflow;
    logic          div_zero;
    logic [OW-1:0] quotient;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [OW-1:0] q;
        logic          ov;
        logic          un;
        logic          dz;
    } vec_t;

    typedef struct {
        logic [OW-1:0] q;
        logic          ov;
        logic          un;
        logic          dz;
    } exp_t;

    exp_t sb[$];
    vec_t tv[NV];
    int   total = 0;
    int   bad   = 0;

    fpdivide dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .underflow (underflow),
        .div_zero  (div_zero),
        .quotient  (quotient)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL stale_done: done with nothing pending, q=%h ov=%b un=%b dz=%b",
                         quotient, overflow, underflow, div_zero);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || overflow !== e.ov || underflow !== e.un || div_zero !== e.dz) begin
                    bad++;
                    $display("FAIL result: got q=%h ov=%b un=%b dz=%b, want q=%h ov=%b un=%b dz=%b",
                             quotient, overflow, underflow, div_zero, e.q, e.ov, e.un, e.dz);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_div(input logic [AW-1:0] ia, input logic [BW-1:0] ib,
                           input logic [OW-1:0] eq, input logic eov, input logic eun,
                           input logic edz, input bit intrude);
        exp_t e;
        int   cyc;
        bit   busy_ok;
        e.q  = eq;
        e.ov = eov;
        e.un = eun;
        e.dz = edz;
        a     = ia;
        b     = ib;
        start = 1'b1;
        sb.push_back(e);
        cyc     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                a     = ~ia;
                b     = ~ib;
            end
            if (intrude && cyc == 5) begin
                a     = 14'h0100;
                b     = 12'h180;
                start = 1'b1;
            end
            if (intrude && cyc == 6) start = 1'b0;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && cyc < 40);

        total++;
        if (!done) begin
            bad++;
            $display("FAIL timeout: no done within %0d cycles for a=%h b=%h", cyc, ia, ib);
            void'(sb.pop_back());
        end else if (cyc - 1 != NW + 1) begin
            bad++;
            $display("FAIL latency: got %0d edges, want %0d (a=%h b=%h)", cyc - 1, NW + 1, ia, ib);
        end
        total++;
        if (!busy_ok || busy) begin
            bad++;
            $display("FAIL busy: busy dropped early=%b busy at done=%b, want 0/0 (a=%h b=%h)",
                     !busy_ok, busy, ia, ib);
        end
    endtask

    initial begin
        tv[0]  = '{14'h0300, 12'h0C0, 15'h0400, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{14'h3B00, 12'h100, 15'h7B00, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{14'h0100, 12'h180, 15'h00AA, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{14'h1F00, 12'h040, 15'h3FFF, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{14'h2100, 12'h040, 15'h4000, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{14'h3F00, 12'h000, 15'h4000, 1'b0, 1'b1, 1'b1};
        tv[6]  = '{14'h0000, 12'h000, 15'h3FFF, 1'b1, 1'b0, 1'b1};
        tv[7]  = '{14'h0100, 12'h000, 15'h3FFF, 1'b1, 1'b0, 1'b1};
        tv[8]  = '{14'h2000, 12'h080, 15'h4000, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{14'h1000, 12'h040, 15'h3FFF, 1'b1, 1'b0, 1'b0};
        tv[10] = '{14'h1FFF, 12'h080, 15'h3FFE, 1'b0, 1'b0, 1'b0};
        tv[11] = '{14'h0300, 12'hF40, 15'h7C00, 1'b0, 1'b0, 1'b0};
        tv[12] = '{14'h3D00, 12'hF40, 15'h0400, 1'b0, 1'b0, 1'b0};
        tv[13] = '{14'h0000, 12'hF40, 15'h0000, 1'b0, 1'b0, 1'b0};
        tv[14] = '{14'h3F00, 12'h180, 15'h7F56, 1'b0, 1'b0, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 ||
            overflow !== 1'b0 || underflow !== 1'b0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b q=%h ov=%b un=%b dz=%b, want all 0",
                     busy, done, quotient, overflow, underflow, div_zero);
        end
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_div(tv[i].a, tv[i].b, tv[i].q, tv[i].ov, tv[i].un, tv[i].dz, 1'b0);
        end

        run_div(14'h0300, 12'h0C0, 15'h0400, 1'b0, 1'b0, 1'b0, 1'b1);
        run_div(14'h3B00, 12'h100, 15'h7B00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort a division part-way through with an asynchronous reset.
        a     = 14'h0100;
        b     = 12'h180;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 ||
            overflow !== 1'b0 || underflow !== 1'b0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: busy=%b done=%b q=%h ov=%b un=%b dz=%b, want all 0",
                     busy, done, quotient, overflow, underflow, div_zero);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (busy !== 1'b0 || quotient !== '0) begin
            bad++;
            $display("FAIL post_reset_idle: busy=%b q=%h, want 0/0000", busy, quotient);
        end
        run_div(14'h0300, 12'h0C0, 15'h0400, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (30) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpdivide.md
# fpdivide

Sequential signed fixed-point divider, the inverse companion to `fpmultiply` in the arithmetic datapath. It computes `quotient = a / b` with a restoring long-division engine on operand magnitudes, one quotient bit per clock. The result is re-signed, saturated into the output Q-format, and flagged with overflow, underflow and divide-by-zero. A start/busy/done handshake lets a controller issue one division at a time.

## Interface
Parameters:
- `int1`, 6: integer bits of dividend `a`, sign included.
- `frac1`, 8: fraction bits of `a`.
- `int2`, 5: integer bits of divisor `b`, sign included.
- `frac2`, 7: fraction bits of `b`.
- `out_int`, 6: integer bits of `quotient`, sign included.
- `out_frac`, 9: fraction bits of `quotient`.
- Derived values:
  - `AW = int1+frac1`
  - `BW = int2+frac2`
  - `OW = out_int+out_frac`
  - `SH = out_frac+frac2-frac1`, which must be ≥ 0
  - `NW = AW+SH`, the iteration count; 22 with the default parameters.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  AW  signed dividend; captured when start is accepted.
- `b`  in  BW  signed divisor; captured when start is accepted.
- `busy`  out  1  high from acceptance until the cycle done is asserted.
- `done`  out  1  one-cycle pulse; outputs below are valid from this cycle.
- `overflow`  out  1  positive saturation.
- `underflow`  out  1  negative saturation.
- `div_zero`  out  1  `b` was 0.
- `quotient`  out  OW  signed result.

## Operation
- States: IDLE, DIV, FIN.
- IDLE, on `start`=1:
  - Register `sign = a[AW-1]^b[BW-1]`, `|a|` (AW bits unsigned), `|b|` (BW bits), `bz = (b==0)`.
  - Clear the remainder and the iteration counter.
  - Go to DIV.
- DIV, NW cycles: restoring division of the numerator `|a|<<SH` by `|b|`.
  - Each cycle: `rem = {rem, next numerator bit}`.
  - If `rem ≥ |b|`: subtract `|b|` and shift 1 into the quotient magnitude, else shift 0.
  - Counter reaching NW-1 moves the FSM to FIN.
  - The quotient magnitude register is NW bits wide, with no internal truncation.
- FIN, one cycle, computes the result and returns to IDLE:
  - `bz`: `quotient` = sign of `a` ? min (`1` followed by zeros) : max (`0` followed by ones). `underflow` or `overflow` set accordingly; `div_zero`=1. A zero dividend with zero divisor gives max and `overflow`.
  - `sign`=0 and magnitude > 2^(OW-1)-1: max, `overflow`=1.
  - `sign`=1 and magnitude > 2^(OW-1): min, `underflow`=1.
  - Otherwise: `quotient` = ±magnitude, with the fraction truncated toward zero, and all flags 0.
  - A zero magnitude with `sign`=1 yields 0.
- Outputs and flags hold their values until the next FIN.
- `start` while busy is ignored; no queueing.
- The latency is fixed at NW+2 edges regardless of operand values, including `b`=0.

## Timing
- Reset (`rst`=0), asynchronous, any state:
  - FSM goes to IDLE.
  - `busy`=0, `done`=0, `overflow`=0, `underflow`=0, `div_zero`=0, `quotient`=0.
  - Any in-flight division is discarded with no `done`.
- Release of reset takes effect synchronously at the next edge. `start` is accepted no earlier than the first edge with `rst`=1.
- `start` sampled high at edge k in IDLE:
  - `busy`=1 after edge k.
  - DIV runs edges k+1 … k+NW.
  - FIN result is registered at edge k+NW+1: `done`=1 and `busy`=0 for that cycle. The default latency is k+23.
- `done` falls after edge k+NW+2. A new `start` may be sampled at edge k+NW+2, giving back-to-back throughput of one division per NW+2 cycles.
- `a` and `b` may change freely after the acceptance edge.

## Test plan
- a=0x0300 (3.0), b=0x0C0 (1.5) → `quotient`=0x0400 (2.0), all flags 0. `done` exactly 23 edges after the start edge; `busy` high for cycles 1..22.
- a=-5.0 (0x3B00), b=0x100 (2.0) → `quotient`=0x7B00 (-2.5), flags 0. Also a=1.0 (0x0100), b=0x180 (3.0) → 0x00AA (truncated 0.33203).
- Saturation:
  - a=31.0 (0x1F00), b=0x040 (0.5) → 0x3FFF, `overflow`=1.
  - a=-31.0, b=0x040 → 0x4000, `underflow`=1.
- Divide-by-zero:
  - a=-1.0, b=0 → 0x4000, `underflow`=1, `div_zero`=1, `done` still at 23.
  - a=0, b=0 → 0x3FFF, `overflow`=1, `div_zero`=1.
- Handshake:
  - A second `start` with new operands pulsed during `busy` is ignored; the first result is unchanged.
  - `start` at the edge after `done` begins the next division.
- `rst`=0 asserted asynchronously mid-DIV, e.g. cycle 10, drives all outputs to 0 immediately. After release, no stale `done` appears, and a fresh 3.0/1.5 division returns 0x0400.
